// File: rtl/uart_line_arbiter.sv
// Line-locking arbiter: shares one UART TX byte stream among NUM_REQ sources so that
// text lines never interleave; round-robin between lines, idle-timeout forced release.
module uart_line_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    localparam int unsigned ID_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   tx_valid,
    output logic [7:0]             tx_data,
    input  logic                   tx_ready,
    output logic [ID_W-1:0]        owner,
    output logic                   owner_valid,
    output logic                   timeout_pulse
);

    localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);
    localparam logic [7:0]       NEWLINE  = 8'h0a;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   owner_q, owner_d;
    logic              owner_valid_q, owner_valid_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic              timeout_q, timeout_d;

    logic [7:0]        req_byte [NUM_REQ];
    logic              grant_found;
    logic [ID_W-1:0]   grant_id;
    logic [ID_W-1:0]   cand_id;
    logic [ID_W-1:0]   next_ptr;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_byte[g] = req_data[8*g +: 8];
    end

    // Round-robin search starting at rr_ptr
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand_id     = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand_id = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand_id]) begin
                grant_found = 1'b1;
                grant_id    = cand_id;
            end
        end
    end

    assign next_ptr = (owner_q == ID_LAST) ? '0 : owner_q + ID_W'(1);

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        owner_valid_d = owner_valid_q;
        rr_ptr_d      = rr_ptr_q;
        idle_cnt_d    = idle_cnt_q;
        timeout_d     = 1'b0;
        tx_valid      = 1'b0;
        tx_data       = '0;
        req_ready     = '0;

        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    owner_d       = grant_id;
                    owner_valid_d = 1'b1;
                    idle_cnt_d    = '0;
                    state_d       = LOCKED;
                end
            end
            LOCKED: begin
                tx_valid           = req_valid[owner_q];
                tx_data            = req_byte[owner_q];
                req_ready[owner_q] = tx_ready;
                if (req_valid[owner_q]) begin
                    idle_cnt_d = '0;
                    if (tx_ready && (req_byte[owner_q] == NEWLINE)) begin
                        state_d       = IDLE;
                        owner_valid_d = 1'b0;
                        rr_ptr_d      = next_ptr;
                    end
                end else if (idle_cnt_q == CNT_LAST) begin
                    state_d       = IDLE;
                    owner_valid_d = 1'b0;
                    rr_ptr_d      = next_ptr;
                    timeout_d     = 1'b1;
                end else if (idle_cnt_q != CNT_MAX) begin
                    idle_cnt_d = idle_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            owner_q       <= '0;
            owner_valid_q <= 1'b0;
            rr_ptr_q      <= '0;
            idle_cnt_q    <= '0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            owner_valid_q <= owner_valid_d;
            rr_ptr_q      <= rr_ptr_d;
            idle_cnt_q    <= idle_cnt_d;
            timeout_q     <= timeout_d;
        end
    end

    assign owner         = owner_q;
    assign owner_valid   = owner_valid_q;
    assign timeout_pulse = timeout_q;

endmodule

// File: tb/tb_uart_line_arbiter.sv
// Directed bench for uart_line_arbiter: reset, line locking, round-robin, timeout,
// backpressure and mid-line reset, with hand-computed expectations.
module tb_uart_line_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ID_W    = 2;

    logic                 clk;
    logic                 resetn;
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_valid;
    logic [7:0]           tx_data;
    logic                 tx_ready;
    logic [ID_W-1:0]      owner;
    logic                 owner_valid;
    logic                 timeout_pulse;

    int n_pass = 0;
    int n_chk  = 0;

    uart_line_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (8)
    ) u_dut (
        .clk           (clk),
        .resetn        (resetn),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .tx_ready      (tx_ready),
        .owner         (owner),
        .owner_valid   (owner_valid),
        .timeout_pulse (timeout_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int order [5] = '{0, 1, 2, 3, 0};
    logic saw_pulse;

    initial begin
        resetn    = 1'b0;
        req_valid = 4'hF;
        req_data  = {4{8'h55}};
        tx_ready  = 1'b1;

        // Reset with every requester asking
        cyc(); cyc();
        chk("rst_tx_valid", 32'(tx_valid), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_owner_valid", 32'(owner_valid), 0);
        chk("rst_timeout", 32'(timeout_pulse), 0);
        chk("rst_owner", 32'(owner), 0);

        // Line "AB\n" from req0 while req1 waits
        req_valid = 4'h0;
        resetn    = 1'b1;
        cyc();
        chk("idle_no_req", 32'(owner_valid), 0);
        req_valid = 4'b0011;
        req_data  = {8'h00, 8'h00, 8'h5a, 8'h41};
        #1;
        chk("idle_no_byte", 32'(tx_valid), 0);
        cyc();
        chk("l0_owner_valid", 32'(owner_valid), 1);
        chk("l0_owner", 32'(owner), 0);
        chk("l0_tx_valid", 32'(tx_valid), 1);
        chk("l0_byte_a", 32'(tx_data), 32'h41);
        chk("l0_ready", 32'(req_ready), 32'b0001);
        cyc();
        req_data[7:0] = 8'h42;
        #1;
        chk("l0_byte_b", 32'(tx_data), 32'h42);
        chk("l0_owner_hold", 32'(owner), 0);
        cyc();
        req_data[7:0] = 8'h0a;
        #1;
        chk("l0_byte_nl", 32'(tx_data), 32'h0a);
        chk("l0_nl_ready", 32'(req_ready), 32'b0001);
        cyc();
        req_valid = 4'b0010;
        #1;
        chk("l0_released", 32'(owner_valid), 0);
        chk("l0_rel_tx_valid", 32'(tx_valid), 0);
        chk("l0_owner_kept", 32'(owner), 0);
        cyc();
        chk("l1_granted", 32'(owner_valid), 1);
        chk("l1_owner", 32'(owner), 1);
        chk("l1_byte", 32'(tx_data), 32'h5a);
        req_data[15:8] = 8'h0a;
        cyc();
        req_valid = 4'h0;

        // Round-robin from a fresh reset
        #2;
        resetn = 1'b0;
        #1;
        resetn    = 1'b1;
        req_valid = 4'hF;
        req_data  = {4{8'h78}};
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("rr_owner_valid", 32'(owner_valid), 1);
            chk("rr_owner", 32'(owner), 32'(order[k]));
            chk("rr_byte_x", 32'(tx_data), 32'h78);
            chk("rr_ready", 32'(req_ready), 32'(1) << order[k]);
            req_data[8*order[k] +: 8] = 8'h0a;
            #1;
            chk("rr_byte_nl", 32'(tx_data), 32'h0a);
            cyc();
            req_data = {4{8'h78}};
            #1;
            chk("rr_released", 32'(owner_valid), 0);
            chk("rr_idle_tx", 32'(tx_valid), 0);
        end

        // Timeout: req2 sends "Hi" then goes quiet, req3 waits
        req_valid = 4'b0100;
        req_data  = {8'h00, 8'h48, 8'h00, 8'h00};
        cyc();
        chk("to_owner", 32'(owner), 2);
        chk("to_byte_h", 32'(tx_data), 32'h48);
        cyc();
        req_data[23:16] = 8'h69;
        #1;
        chk("to_byte_i", 32'(tx_data), 32'h69);
        cyc();
        req_valid = 4'b1000;
        req_data  = {8'h51, 8'h00, 8'h00, 8'h00};
        #1;
        chk("to_idle_tx", 32'(tx_valid), 0);
        repeat (7) cyc();
        chk("to_still_locked", 32'(owner_valid), 1);
        chk("to_no_pulse_yet", 32'(timeout_pulse), 0);
        cyc();
        chk("to_released", 32'(owner_valid), 0);
        chk("to_pulse", 32'(timeout_pulse), 1);
        cyc();
        chk("to_pulse_once", 32'(timeout_pulse), 0);
        chk("to_next_owner", 32'(owner), 3);
        chk("to_next_valid", 32'(owner_valid), 1);

        // Backpressure: owner valid but serializer stalled
        tx_ready  = 1'b0;
        saw_pulse = 1'b0;
        repeat (2000) begin
            cyc();
            if (timeout_pulse || !owner_valid) saw_pulse = 1'b1;
        end
        chk("bp_no_release", 32'(saw_pulse), 0);
        chk("bp_owner", 32'(owner), 3);
        chk("bp_ready_low", 32'(req_ready), 0);
        chk("bp_tx_valid", 32'(tx_valid), 1);
        tx_ready = 1'b1;
        #1;
        chk("bp_ready_rise", 32'(req_ready), 32'b1000);
        chk("bp_byte", 32'(tx_data), 32'h51);
        cyc();
        req_data[31:24] = 8'h0a;
        cyc();
        req_valid = 4'h0;
        #1;
        chk("bp_line_done", 32'(owner_valid), 0);

        // Reset in the middle of "ABC\n" from req1
        req_valid = 4'b0010;
        req_data  = {8'h00, 8'h00, 8'h41, 8'h00};
        cyc();
        chk("mr_owner", 32'(owner), 1);
        cyc();
        req_data[15:8] = 8'h42;
        cyc();
        req_data[15:8] = 8'h43;
        req_valid      = 4'b0011;
        #1;
        chk("mr_byte_c", 32'(tx_data), 32'h43);
        resetn = 1'b0;
        #1;
        chk("mr_tx_valid", 32'(tx_valid), 0);
        chk("mr_req_ready", 32'(req_ready), 0);
        chk("mr_owner_valid", 32'(owner_valid), 0);
        chk("mr_owner_zero", 32'(owner), 0);
        chk("mr_timeout", 32'(timeout_pulse), 0);
        resetn = 1'b1;
        cyc();
        chk("mr_regrant_valid", 32'(owner_valid), 1);
        chk("mr_regrant_owner", 32'(owner), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
